seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Controller that sequences a programmable serial pattern detector (e.g. 1101).
//  Accepts a parallel word over valid/ready, shifts it out MSB-first one bit
//  per clock and flags overlapping pattern matches as a Mealy pulse.
//  Counts matches per job and reports completion; sits between the word source
//  and the detector/statistics logic.
// PARAMETERS
//  WORD_W  16  bits per accepted word (>= PAT_W)
//  PAT_W   4   pattern length in bits
//  CNT_W   5   match counter width; saturates at 2**CNT_W-1
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  word_valid  in   1       source has a word
//  word_in     in   WORD_W  word to scan, sent MSB-first
//  pattern     in   PAT_W   pattern, MSB = first bit; latched at accept
//  chain       in   1       at accept: 1 = keep history and accumulate count
//  abort       in   1       synchronous job abort
//  word_ready  out  1       controller can accept a word (IDLE only)
//  bit_out     out  1       current serial bit
//  bit_valid   out  1       bit_out is valid this cycle
//  match       out  1       Mealy match pulse, aligned with bit_out
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle end-of-job pulse
//  match_cnt   out  CNT_W   matches for current/last job; held until next accept
// BEHAVIOUR
//  - Reset (reset=0, async): IDLE; word_ready=1; all other outputs 0; history,
//    bit counter and match_cnt cleared. Reset mid-job abandons it, no done.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: word_ready=1. Accept on word_valid&&word_ready at edge E0: latch
//    word_in, pattern; if chain=0 clear history, seen-count and match_cnt;
//    if chain=1 keep all three. Go to SHIFT.
//  - SHIFT: cycles k=0..WORD_W-1 after E0: bit_valid=1,
//    bit_out=word[WORD_W-1-k]. History = last PAT_W-1 bits shifted out.
//    match=1 iff seen >= PAT_W-1 and {history,bit_out}==pattern (combinational
//    in the same cycle). Overlapping matches allowed. seen saturates at PAT_W-1.
//  - match_cnt increments at the edge ending a match cycle; saturates, no wrap.
//  - After k=WORD_W-1 -> DONE: done=1, bit_valid=0, busy=1, for one cycle; then
//    IDLE. Latency: first bit 1 cycle after E0; done at E0+WORD_W+1;
//    word_ready back at E0+WORD_W+2.
//  - abort=1 in SHIFT or DONE: next edge -> IDLE, no done pulse; history and seen
//    cleared; match_cnt holds its value. abort in IDLE ignored.
//  - abort in the same cycle as an accept: accept wins, abort ignored.
//  - word_valid ignored outside IDLE; pattern/chain sampled only at accept.
// TESTING
//  1 pattern=1101, chain=0, word=0xDDDD -> match at k=3,7,11,15; done at E0+17;
//    match_cnt=4.
//  2 Overlap: pattern=1101, word=0x00DB -> match at k=11,14; match_cnt=2.
//  3 Chain: 0x0003 (chain=0) then 0x4000 (chain=1) -> match at word2 k=1,
//    match_cnt=1; same pair with chain=0 on word2 -> 0 matches.
//  4 Saturation: CNT_W=2, word=0xDDDD -> match_cnt=3, no wrap to 0.
//  5 abort at k=5 of 0xDDDD -> IDLE next cycle, no done, match_cnt=1,
//    word_ready=1.
//  6 reset low at k=8 -> all outputs 0 at once, word_ready=1 after release;
//    new job (0xDDDD) gives match_cnt=4.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Serial pattern-detector sequencer: accepts a word, shifts it out MSB-first,
// flags overlapping pattern matches (Mealy) and counts them per job.
module seq_detect_ctrl #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              chain,
    input  logic              abort,
    output logic              word_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SEEN_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(WORD_W - 1);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [PAT_W-2:0]    hist_q, hist_d;
    logic [SEEN_W-1:0]   seen_q, seen_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAT_W-1:0]    window;

    // The word register shifts left each bit, so the MSB is always the current bit.
    always_comb begin
        word_ready = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        bit_valid  = (state_q == S_SHIFT);
        done       = (state_q == S_DONE);
        bit_out    = bit_valid & shreg_q[WORD_W-1];
        window     = {hist_q, bit_out};
        match      = bit_valid && (seen_q == SEEN_MAX) && (window == pat_q);
        match_cnt  = cnt_q;
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        pat_d    = pat_q;
        hist_d   = hist_q;
        seen_d   = seen_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (word_valid) begin
                    shreg_d  = word_in;
                    pat_d    = pattern;
                    bitcnt_d = '0;
                    state_d  = S_SHIFT;
                    if (!chain) begin
                        hist_d = '0;
                        seen_d = '0;
                        cnt_d  = '0;
                    end
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    // Count is kept for inspection; detector history is not.
                    hist_d  = '0;
                    seen_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    shreg_d  = shreg_q << 1;
                    hist_d   = window[PAT_W-2:0];
                    seen_d   = (seen_q == SEEN_MAX) ? seen_q : seen_q + SEEN_W'(1);
                    bitcnt_d = bitcnt_q + BC_W'(1);
                    if (match && (cnt_q != CNT_MAX))
                        cnt_d = cnt_q + CNT_W'(1);
                    if (bitcnt_q == LAST_BIT)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (abort) begin
                    hist_d = '0;
                    seen_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            pat_q    <= '0;
            hist_q   <= '0;
            seen_q   <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            pat_q    <= pat_d;
            hist_q   <= hist_d;
            seen_q   <= seen_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Table-driven bench for seq_detect_ctrl with a per-bit scoreboard; a second
// instance with a 2-bit counter checks saturation on the same stimulus.
module tb_seq_detect_ctrl;

    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic word_valid = 1'b0;
    logic [WORD_W-1:0] word_in = '0;
    logic [PAT_W-1:0]  pattern = '0;
    logic chain = 1'b0;
    logic abort = 1'b0;

    logic word_ready, bit_out, bit_valid, match, busy, done;
    logic [4:0] match_cnt;
    logic s_word_ready, s_bit_out, s_bit_valid, s_match, s_busy, s_done;
    logic [1:0] s_match_cnt;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_in(word_in),
        .pattern(pattern), .chain(chain), .abort(abort),
        .word_ready(word_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .match(match), .busy(busy), .done(done), .match_cnt(match_cnt));

    seq_detect_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_in(word_in),
        .pattern(pattern), .chain(chain), .abort(abort),
        .word_ready(s_word_ready), .bit_out(s_bit_out), .bit_valid(s_bit_valid),
        .match(s_match), .busy(s_busy), .done(s_done), .match_cnt(s_match_cnt));

    typedef struct {
        logic [WORD_W-1:0] word;
        logic [PAT_W-1:0]  pat;
        logic              chain;
        logic [WORD_W-1:0] mmask;     // bit k set = match expected at shift step k
        int                cnt;       // expected match_cnt (-1: skip)
        int                cnt_s;     // expected 2-bit match_cnt (-1: skip)
        int                abort_k;   // step at which abort is raised (-1: none)
        int                rst_k;     // step at which reset is pulled (-1: none)
        logic              abort_acc; // raise abort together with the accept
        string             name;
    } vec_t;

    typedef struct {
        int   k;
        logic b;
        logic m;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int   cyc;
        bit   fin;
        int   last_k;
        exp_t e;
        cyc = 0;
        fin = 0;
        chk({v.name, "_ready_in"}, {31'b0, word_ready}, 32'd1);
        last_k = WORD_W - 1;
        if (v.abort_k >= 0) last_k = v.abort_k;
        if (v.rst_k >= 0)   last_k = v.rst_k;
        for (int k = 0; k <= last_k; k++) begin
            e.k = k;
            e.b = v.word[WORD_W-1-k];
            e.m = v.mmask[k];
            sb.push_back(e);
        end
        word_valid = 1'b1;
        word_in    = v.word;
        pattern    = v.pat;
        chain      = v.chain;
        abort      = v.abort_acc;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        word_in    = '0;
        chain      = 1'b0;
        abort      = 1'b0;
        while (!fin && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bit_valid) begin
                if (sb.size() == 0) begin
                    chk({v.name, "_extra_bit"}, 32'd1, 32'd0);
                    fin = 1;
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("%s_bit_k%0d", v.name, e.k), {31'b0, bit_out}, {31'b0, e.b});
                    chk($sformatf("%s_match_k%0d", v.name, e.k), {31'b0, match}, {31'b0, e.m});
                    if (e.k == v.abort_k) begin
                        abort = 1'b1;
                        @(posedge clk);
                        #1 abort = 1'b0;
                        @(negedge clk);
                        chk({v.name, "_abort_ready"}, {31'b0, word_ready}, 32'd1);
                        chk({v.name, "_abort_busy"}, {31'b0, busy}, 32'd0);
                        chk({v.name, "_abort_nodone"}, {31'b0, done}, 32'd0);
                        fin = 1;
                    end else if (e.k == v.rst_k) begin
                        reset = 1'b0;
                        #1;
                        chk({v.name, "_rst_outs"},
                            {26'b0, bit_out, bit_valid, match, busy, done, |match_cnt}, 32'd0);
                        chk({v.name, "_rst_ready"}, {31'b0, word_ready}, 32'd1);
                        sb.delete();
                        repeat (2) @(negedge clk);
                        reset = 1'b1;
                        @(negedge clk);
                        chk({v.name, "_rel_ready"}, {31'b0, word_ready}, 32'd1);
                        chk({v.name, "_rel_cnt"}, {27'b0, match_cnt}, 32'd0);
                        fin = 1;
                    end
                end
            end else if (done) begin
                chk({v.name, "_done_lat"}, cyc, WORD_W + 1);
                chk({v.name, "_done_busy"}, {31'b0, busy}, 32'd1);
                @(negedge clk);
                chk({v.name, "_ready_back"}, {31'b0, word_ready}, 32'd1);
                chk({v.name, "_done_pulse"}, {31'b0, done}, 32'd0);
                fin = 1;
            end
        end
        if (!fin) chk({v.name, "_timeout"}, 32'd1, 32'd0);
        chk({v.name, "_sb_drained"}, sb.size(), 32'd0);
        sb.delete();
        if (v.cnt >= 0)   chk({v.name, "_cnt"}, {27'b0, match_cnt}, v.cnt);
        if (v.cnt_s >= 0) chk({v.name, "_cnt_sat"}, {30'b0, s_match_cnt}, v.cnt_s);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{16'hDDDD, 4'b1101, 1'b0, 16'h8888,  4,  3, -1, -1, 1'b0, "t1_dddd"};
        tbl[1]  = '{16'h00DB, 4'b1101, 1'b0, 16'h4800,  2,  2, -1, -1, 1'b0, "t2_overlap"};
        tbl[2]  = '{16'h0003, 4'b1101, 1'b0, 16'h0000,  0,  0, -1, -1, 1'b0, "t3_w1"};
        tbl[3]  = '{16'h4000, 4'b1101, 1'b1, 16'h0002,  1,  1, -1, -1, 1'b0, "t3_chain"};
        tbl[4]  = '{16'h0003, 4'b1101, 1'b0, 16'h0000,  0,  0, -1, -1, 1'b0, "t3_w1b"};
        tbl[5]  = '{16'h4000, 4'b1101, 1'b0, 16'h0000,  0,  0, -1, -1, 1'b0, "t3_nochain"};
        tbl[6]  = '{16'hDDDD, 4'b1101, 1'b0, 16'h8888,  1,  1,  5, -1, 1'b0, "t5_abort"};
        tbl[7]  = '{16'hDDDD, 4'b1101, 1'b0, 16'h8888, -1, -1, -1,  8, 1'b0, "t6_reset"};
        tbl[8]  = '{16'hDDDD, 4'b1101, 1'b0, 16'h8888,  4,  3, -1, -1, 1'b0, "t6_after"};
        tbl[9]  = '{16'h0000, 4'b0000, 1'b0, 16'hFFF8, 13,  3, -1, -1, 1'b0, "zeros"};
        tbl[10] = '{16'hFFFF, 4'b1111, 1'b1, 16'hFFF8, 26,  3, -1, -1, 1'b1, "ones_abortacc"};
        tbl[11] = '{16'h0000, 4'b0000, 1'b1, 16'hFFF8, 31,  3, -1, -1, 1'b0, "sat31"};

        #12;
        chk("reset_outs", {26'b0, bit_out, bit_valid, match, busy, done, |match_cnt}, 32'd0);
        chk("reset_ready", {31'b0, word_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_job(tbl[i]);
            if (i == 6) begin
                // abort while idle must not disturb anything
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                @(negedge clk);
                chk("idle_abort_ready", {31'b0, word_ready}, 32'd1);
                chk("idle_abort_cnt", {27'b0, match_cnt}, 32'd1);
            end
        end

        // word_valid and pattern changes outside IDLE have no effect
        word_valid = 1'b1;
        word_in    = 16'hDDDD;
        pattern    = 4'b1101;
        @(posedge clk);
        #1 word_in = 16'h0000;
        pattern    = 4'b0000;
        @(negedge clk);
        chk("busy_ignore_valid", {31'b0, word_ready}, 32'd0);
        word_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("latched_pattern_cnt", {27'b0, match_cnt}, 32'd4);
        chk("final_idle", {31'b0, word_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
